// File: rtl/buffer_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// buffer_access_arbiter_if
// Bundles the requester-facing handshake and the associative-buffer command
// bus of the buffer access arbiter.
//   req/req_ctrl/req_key/req_data : per-requester level request and operands
//   ack/resp_data/resp_valid      : one-hot completion pulse and response
//   dump_req/dump_ack             : readout request and end-of-window pulse
//   busy                          : arbiter is not idle
//   buf_*                         : command bus to / response from the buffer
// Modport slave is taken by the arbiter, master by its environment.
// ---------------------------------------------------------------------------
interface buffer_access_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int KEY_WIDTH  = 8,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [2*NUM_REQ-1:0]          req_ctrl;
   logic [KEY_WIDTH*NUM_REQ-1:0]  req_key;
   logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic [DATA_WIDTH-1:0]         resp_data;
   logic                          resp_valid;
   logic                          dump_req;
   logic                          dump_ack;
   logic                          busy;
   logic                          buf_cmd_valid;
   logic [1:0]                    buf_ctrl;
   logic [KEY_WIDTH-1:0]          buf_key;
   logic [DATA_WIDTH-1:0]         buf_data_in;
   logic                          buf_start_reading;
   logic [DATA_WIDTH-1:0]         buf_data_out;
   logic                          buf_valid;

   modport slave (
      input  req, req_ctrl, req_key, req_data, dump_req, buf_data_out, buf_valid,
      output ack, resp_data, resp_valid, dump_ack, busy,
             buf_cmd_valid, buf_ctrl, buf_key, buf_data_in, buf_start_reading
   );

   modport master (
      output req, req_ctrl, req_key, req_data, dump_req, buf_data_out, buf_valid,
      input  ack, resp_data, resp_valid, dump_ack, busy,
             buf_cmd_valid, buf_ctrl, buf_key, buf_data_in, buf_start_reading
   );
endinterface

// File: rtl/buffer_access_arbiter.sv
// ---------------------------------------------------------------------------
// buffer_access_arbiter
// Shares one associative buffer between NUM_REQ round-robin requesters and a
// dump (readout) requester. A granted command is latched, presented to the
// buffer for exactly one cycle, the buffer response is captured and returned
// with a one-cycle one-hot ack. A dump pulses buf_start_reading and then
// blocks all access for DUMP_CYCLES cycles, ending with a dump_ack pulse.
// Ports:
//   clk        : clock, rising edge
//   sync_reset : synchronous active-high reset
//   bus        : buffer_access_arbiter_if.slave (requesters, dump, buffer)
// All outputs are registers; buf_ctrl/buf_key/buf_data_in are the latched
// command and are qualified by buf_cmd_valid.
// ---------------------------------------------------------------------------
module buffer_access_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int KEY_WIDTH   = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int DUMP_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  sync_reset,
   buffer_access_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(DUMP_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE      = 3'd1,
      ST_RESP       = 3'd2,
      ST_DUMP_START = 3'd3,
      ST_DUMP_WAIT  = 3'd4
   } state_t;

   state_t                state_r, state_nx_s;
   logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
   logic [IDX_W-1:0]      rr_ptr_r;
   logic [IDX_W-1:0]      win_r;
   logic [IDX_W-1:0]      win_idx_s;
   logic                  win_found_s;
   logic [1:0]            ctrl_r;
   logic [KEY_WIDTH-1:0]  key_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [DATA_WIDTH-1:0] resp_data_r;
   logic                  resp_valid_r;
   logic [NUM_REQ-1:0]    ack_r, ack_nx_s;
   logic                  dump_ack_r, dump_ack_nx_s;
   logic                  busy_r;
   logic                  cmd_valid_r;
   logic                  start_rd_r;
   logic                  ld_cmd_s;
   logic                  cap_resp_s;
   logic                  adv_ptr_s;

   // Index 'off' places above 'base', wrapped into 0..NUM_REQ-1.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end else begin
         sum = sum;
      end
      return IDX_W'(sum);
   endfunction

   // Round-robin pick: first active request at or above the pointer, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {IDX_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found_s && bus.req[wrap_idx(rr_ptr_r, k)]) begin
            win_found_s = 1'b1;
            win_idx_s   = wrap_idx(rr_ptr_r, k);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next state, latch enables and next values of the registered outputs.
   always_comb begin
      state_nx_s    = state_r;
      cnt_nx_s      = cnt_r;
      ld_cmd_s      = 1'b0;
      cap_resp_s    = 1'b0;
      adv_ptr_s     = 1'b0;
      ack_nx_s      = {NUM_REQ{1'b0}};
      dump_ack_nx_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // Dump outranks every ordinary requester.
            if (bus.dump_req) begin
               state_nx_s = ST_DUMP_START;
            end else if (win_found_s) begin
               state_nx_s = ST_ISSUE;
               ld_cmd_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_nx_s = ST_RESP;
            cap_resp_s = 1'b1;
         end
         ST_RESP: begin
            state_nx_s = ST_IDLE;
            adv_ptr_s  = 1'b1;
         end
         ST_DUMP_START: begin
            state_nx_s = ST_DUMP_WAIT;
            cnt_nx_s   = {CNT_W{1'b0}};
         end
         ST_DUMP_WAIT: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = ST_IDLE;
            end else begin
               cnt_nx_s = cnt_r + CNT_W'(1'b1);
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      if (state_nx_s == ST_RESP) begin
         ack_nx_s = NUM_REQ'(1'b1) << win_r;
      end else begin
         ack_nx_s = {NUM_REQ{1'b0}};
      end

      // The last window cycle is the one whose counter value is DUMP_CYCLES-1.
      if ((state_nx_s == ST_DUMP_WAIT) && (cnt_nx_s == CNT_LAST)) begin
         dump_ack_nx_s = 1'b1;
      end else begin
         dump_ack_nx_s = 1'b0;
      end
   end

   // State, pointer, operand latches, response capture and output registers.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         rr_ptr_r     <= {IDX_W{1'b0}};
         win_r        <= {IDX_W{1'b0}};
         ctrl_r       <= 2'b00;
         key_r        <= {KEY_WIDTH{1'b0}};
         data_r       <= {DATA_WIDTH{1'b0}};
         resp_data_r  <= {DATA_WIDTH{1'b0}};
         resp_valid_r <= 1'b0;
         ack_r        <= {NUM_REQ{1'b0}};
         dump_ack_r   <= 1'b0;
         busy_r       <= 1'b0;
         cmd_valid_r  <= 1'b0;
         start_rd_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         ack_r       <= ack_nx_s;
         dump_ack_r  <= dump_ack_nx_s;
         busy_r      <= (state_nx_s != ST_IDLE);
         cmd_valid_r <= (state_nx_s == ST_ISSUE);
         start_rd_r  <= (state_nx_s == ST_DUMP_START);
         if (ld_cmd_s) begin
            win_r  <= win_idx_s;
            ctrl_r <= bus.req_ctrl[2*int'(win_idx_s) +: 2];
            key_r  <= bus.req_key[KEY_WIDTH*int'(win_idx_s) +: KEY_WIDTH];
            data_r <= bus.req_data[DATA_WIDTH*int'(win_idx_s) +: DATA_WIDTH];
         end
         // The buffer answers combinationally while the command is presented.
         if (cap_resp_s) begin
            resp_data_r  <= bus.buf_data_out;
            resp_valid_r <= bus.buf_valid;
         end
         if (adv_ptr_s) begin
            if (win_r == IDX_LAST) begin
               rr_ptr_r <= {IDX_W{1'b0}};
            end else begin
               rr_ptr_r <= win_r + IDX_W'(1'b1);
            end
         end
      end
   end

   assign bus.ack               = ack_r;
   assign bus.dump_ack          = dump_ack_r;
   assign bus.busy              = busy_r;
   assign bus.buf_cmd_valid     = cmd_valid_r;
   assign bus.buf_start_reading = start_rd_r;
   assign bus.buf_ctrl          = ctrl_r;
   assign bus.buf_key           = key_r;
   assign bus.buf_data_in       = data_r;
   assign bus.resp_data         = resp_data_r;
   assign bus.resp_valid        = resp_valid_r;
endmodule

// File: tb/tb_buffer_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buffer_access_arbiter
// Drives the arbiter through directed scenarios and a long randomized run and
// compares every output, every cycle, against a transaction-level model that
// tracks the operation in flight and its age in cycles.
// ---------------------------------------------------------------------------
module tb_buffer_access_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int KEY_WIDTH   = 8;
   localparam int DATA_WIDTH  = 8;
   localparam int DUMP_CYCLES = 16;

   logic clk = 1'b0;
   logic sync_reset;
   always #5 clk = ~clk;

   buffer_access_arbiter_if #(.NUM_REQ(NUM_REQ), .KEY_WIDTH(KEY_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   buffer_access_arbiter #(
      .NUM_REQ(NUM_REQ), .KEY_WIDTH(KEY_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DUMP_CYCLES(DUMP_CYCLES)
   ) dut (
      .clk(clk),
      .sync_reset(sync_reset),
      .bus(bus)
   );

   int checks_cnt = 0;
   int fail_cnt   = 0;

   // Model: m_op 0 = nothing in flight, 1 = lookup/update, 2 = dump.
   int          m_op = 0;
   int          m_age = 0;
   int          m_ptr = 0;
   int          m_win = 0;
   logic [1:0]  m_ctrl = 2'b00;
   logic [7:0]  m_key = 8'h00;
   logic [7:0]  m_data = 8'h00;
   logic [7:0]  m_resp_data = 8'h00;
   logic        m_resp_valid = 1'b0;
   bit          m_armed = 1'b0;

   logic [NUM_REQ-1:0] last_exp_ack;
   logic               last_exp_dack;

   // Observed-event log used by the directed scenarios.
   int cyc = 0;
   int grant_log[$];
   int ack_cyc[NUM_REQ];
   int start_cyc = -1;
   int dack_cyc = -1;
   int ack_pulses = 0;
   int dack_pulses = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance the model across one clock edge using the inputs of this cycle.
   task automatic model_advance();
      bit found;
      if (sync_reset) begin
         m_op = 0; m_age = 0; m_ptr = 0; m_win = 0;
         m_ctrl = 2'b00; m_key = 8'h00; m_data = 8'h00;
         m_resp_data = 8'h00; m_resp_valid = 1'b0;
         m_armed = 1'b1;
      end else if (m_op == 0) begin
         if (bus.dump_req) begin
            m_op = 2; m_age = 1;
         end else if (bus.req != '0) begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
               if (!found && bus.req[(m_ptr + k) % NUM_REQ]) begin
                  found = 1'b1;
                  m_win = (m_ptr + k) % NUM_REQ;
               end
            end
            m_ctrl = bus.req_ctrl[2*m_win +: 2];
            m_key  = bus.req_key[8*m_win +: 8];
            m_data = bus.req_data[8*m_win +: 8];
            m_op = 1; m_age = 1;
         end
      end else begin
         if (m_op == 1 && m_age == 1) begin
            m_resp_data  = bus.buf_data_out;
            m_resp_valid = bus.buf_valid;
         end
         if (m_op == 1 && m_age == 2) begin
            m_ptr = (m_win + 1) % NUM_REQ;
            m_op = 0;
         end else if (m_op == 2 && m_age == DUMP_CYCLES + 1) begin
            m_op = 0;
         end else begin
            m_age++;
         end
      end
   endtask

   // One clock cycle: inputs already applied; check outputs at the falling edge.
   task automatic run_cycle();
      logic [NUM_REQ-1:0] e_ack;
      logic e_cmd, e_start, e_dack, e_busy;
      e_ack   = '0;
      e_cmd   = (m_op == 1 && m_age == 1);
      e_start = (m_op == 2 && m_age == 1);
      e_dack  = (m_op == 2 && m_age == DUMP_CYCLES + 1);
      e_busy  = (m_op != 0);
      if (m_op == 1 && m_age == 2) e_ack[m_win] = 1'b1;
      @(negedge clk);
      if (m_armed) begin
         check_val("ack",           32'(bus.ack),               32'(e_ack));
         check_val("dump_ack",      32'(bus.dump_ack),          32'(e_dack));
         check_val("busy",          32'(bus.busy),              32'(e_busy));
         check_val("buf_cmd_valid", 32'(bus.buf_cmd_valid),     32'(e_cmd));
         check_val("start_reading", 32'(bus.buf_start_reading), 32'(e_start));
         check_val("buf_ctrl",      32'(bus.buf_ctrl),          32'(m_ctrl));
         check_val("buf_key",       32'(bus.buf_key),           32'(m_key));
         check_val("buf_data_in",   32'(bus.buf_data_in),       32'(m_data));
         check_val("resp_data",     32'(bus.resp_data),         32'(m_resp_data));
         check_val("resp_valid",    32'(bus.resp_valid),        32'(m_resp_valid));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.ack[i] === 1'b1) begin
            grant_log.push_back(i);
            ack_cyc[i] = cyc;
            ack_pulses++;
         end
      end
      if (bus.buf_start_reading === 1'b1) start_cyc = cyc;
      if (bus.dump_ack === 1'b1) begin
         dack_cyc = cyc;
         dack_pulses++;
      end
      last_exp_ack  = e_ack;
      last_exp_dack = e_dack;
      model_advance();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_acked();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (last_exp_ack[i]) bus.req[i] = 1'b0;
      end
      if (last_exp_dack) bus.dump_req = 1'b0;
   endtask

   task automatic run_n(input int n);
      for (int c = 0; c < n; c++) begin
         run_cycle();
         drop_acked();
      end
   endtask

   task automatic set_ops(input int i, input logic [1:0] c, input logic [7:0] k, input logic [7:0] d);
      bus.req_ctrl[2*i +: 2] = c;
      bus.req_key[8*i +: 8]  = k;
      bus.req_data[8*i +: 8] = d;
   endtask

   task automatic do_reset();
      bus.req = '0;
      bus.dump_req = 1'b0;
      sync_reset = 1'b1;
      run_cycle();
      sync_reset = 1'b0;
      grant_log.delete();
   endtask

   // Random requester / dump / buffer / reset behaviour for one cycle.
   task automatic drive_random(input int raise_pct, input int dump_pm, input int rst_pm);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (last_exp_ack[i]) begin
            bus.req[i] = 1'b0;
         end else if (!bus.req[i]) begin
            if ($urandom_range(99) < raise_pct) begin
               bus.req[i] = 1'b1;
               set_ops(i, 2'($urandom), 8'($urandom), 8'($urandom));
            end
         end else if ($urandom_range(99) < 10) begin
            set_ops(i, 2'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(99) < 20) bus.req[i] = 1'b0;
         end
      end
      if (last_exp_dack) bus.dump_req = 1'b0;
      else if (!bus.dump_req && $urandom_range(999) < dump_pm) bus.dump_req = 1'b1;
      sync_reset = ($urandom_range(999) < rst_pm);
      bus.buf_data_out = 8'($urandom);
      bus.buf_valid = 1'($urandom);
   endtask

   initial begin
      int t0;
      int base_acks;
      bus.req = '0; bus.req_ctrl = '0; bus.req_key = '0; bus.req_data = '0;
      bus.dump_req = 1'b0; bus.buf_data_out = 8'h00; bus.buf_valid = 1'b0;
      last_exp_ack = '0; last_exp_dack = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) ack_cyc[i] = -1;
      sync_reset = 1'b1;
      @(posedge clk);
      #1;
      run_cycle();
      run_cycle();
      sync_reset = 1'b0;
      run_n(2);

      // Single LOAD from requester 0.
      grant_log.delete();
      set_ops(0, 2'd1, 8'h12, 8'hA5);
      bus.req[0] = 1'b1;
      t0 = cyc;
      run_n(6);
      check_val("A_ack_latency", 32'(ack_cyc[0] - t0), 32'd2);
      check_val("A_grant_count", 32'(grant_log.size()), 32'd1);

      // All four held together: strict order 0..3, three cycles apart.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 2'($urandom), 8'($urandom), 8'($urandom));
      bus.req = 4'b1111;
      t0 = cyc;
      run_n(16);
      check_val("B_grant_count", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
         check_val("B_grant_order", 32'(grant_log[i]), 32'(i));
         check_val("B_ack_time", 32'(ack_cyc[i] - t0), 32'(2 + 3*i));
      end

      // Pointer at 2 after serving requester 1, then 1011 wraps 3,0,1.
      do_reset();
      bus.req[1] = 1'b1;
      run_n(5);
      bus.req = 4'b1011;
      run_n(12);
      check_val("C_grant_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         check_val("C_grant0", 32'(grant_log[1]), 32'd3);
         check_val("C_grant1", 32'(grant_log[2]), 32'd0);
         check_val("C_grant2", 32'(grant_log[3]), 32'd1);
      end

      // Dump and req[1] together: dump first, requester afterwards.
      do_reset();
      bus.dump_req = 1'b1;
      bus.req[1] = 1'b1;
      t0 = cyc;
      ack_cyc[1] = -1;
      run_n(24);
      check_val("D_start_time", 32'(start_cyc - t0), 32'd1);
      check_val("D_dack_time", 32'(dack_cyc - t0), 32'(DUMP_CYCLES + 1));
      check_val("D_ack1_time", 32'(ack_cyc[1] - t0), 32'(DUMP_CYCLES + 4));

      // Response captured in the issue cycle and held afterwards.
      do_reset();
      bus.req[2] = 1'b1;
      bus.buf_data_out = 8'h5C; bus.buf_valid = 1'b1;
      run_n(2);
      bus.buf_data_out = 8'hFF; bus.buf_valid = 1'b0;
      run_n(6);
      check_val("E_resp_data", 32'(bus.resp_data), 32'h5C);
      check_val("E_resp_valid", 32'(bus.resp_valid), 32'd1);

      // Reset during the issue cycle and during the dump window.
      do_reset();
      bus.req[0] = 1'b1;
      run_n(1);
      base_acks = ack_pulses;
      bus.req[0] = 1'b0;
      sync_reset = 1'b1;
      run_cycle();
      sync_reset = 1'b0;
      run_n(5);
      check_val("F_no_ack", 32'(ack_pulses - base_acks), 32'd0);
      bus.dump_req = 1'b1;
      run_n(6);
      base_acks = dack_pulses;
      bus.dump_req = 1'b0;
      sync_reset = 1'b1;
      run_cycle();
      sync_reset = 1'b0;
      run_n(DUMP_CYCLES + 4);
      check_val("F_no_dump_ack", 32'(dack_pulses - base_acks), 32'd0);

      // Long randomized run against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         drive_random(30, 15, 3);
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end
endmodule
